// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//   Receives PS/2 keyboard frames and turns them into make/break key events.
//   The raw ps2_clk/ps2_data lines are synchronised, and each 11-bit frame is
//   framed: start, 8 data bits LSB first, odd parity, stop. Frames that fail
//   the checks are rejected. E0/F0 prefixes are merged into the next byte.
//   The resulting events are queued in a first-word fall-through FIFO.
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   ps2_clk       raw keyboard clock (asynchronous)
//   ps2_data      raw keyboard data (asynchronous)
//   ev_valid      FIFO head holds an event
//   ev_ready      consumer accepts the head event
//   ev_code       scan code of the head event (0 when the FIFO is empty)
//   ev_ext        head event had an E0 prefix
//   ev_break      head event had an F0 prefix (key release)
//   ev_count      number of queued events, 0..FIFO_DEPTH
//   frame_err     1-cycle pulse on a parity, stop-bit or timeout error
//   overflow      1-cycle pulse when an event is dropped because the FIFO is full
module ps2_key_event_ctrl #(
    parameter int TIMEOUT_CYC = 200000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours; = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // ------------------------------------------------------------------
    // Frame FSM with inter-edge timeout
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt_q;
    logic             parity_q;
    logic [7:0]       byte_q;
    logic             byte_ok_q;
    logic             frame_err_q;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;

    // Counts cycles since the last falling edge; only meaningful mid-frame.
    always_ff @(posedge clk) begin
        if (rst || fall || state_q == S_IDLE) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            parity_q    <= 1'b0;
            byte_q      <= '0;
            byte_ok_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_ok_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (tmo_hit) begin
                // Stalled keyboard: drop the partial byte and resync on next start bit.
                state_q     <= S_IDLE;
                shift_q     <= '0;
                bit_cnt_q   <= '0;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {dat_s2_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    S_PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        // Odd parity: data bits plus parity bit must hold an odd number of ones.
                        if (dat_s2_q && (^{shift_q, parity_q})) begin
                            byte_ok_q <= 1'b1;
                            byte_q    <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    logic ext_q, brk_q;
    logic push_req;

    assign push_req = byte_ok_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_ok_q) begin
            if (byte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else begin
                // Flags are consumed even if the FIFO drops the event.
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO, first-word fall-through
    // ------------------------------------------------------------------
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, pop, push;
    logic [9:0]       head;

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = push_req && (!full || pop);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push_req && full && !pop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers/count and the head is masked while empty, so stale data never leaks.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ext_q, brk_q, byte_q};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign ev_valid  = (count_q != '0);
    assign ev_ext    = ev_valid ? head[9]   : 1'b0;
    assign ev_break  = ev_valid ? head[8]   : 1'b0;
    assign ev_code   = ev_valid ? head[7:0] : 8'h00;
    assign ev_count  = count_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl
//   Directed stimulus on the PS/2 lines; expected events are queued as
//   frames are sent and a monitor pops them on each handshake.
module tb_ps2_key_event_ctrl;

    localparam int TMO   = 2000;
    localparam int DEPTH = 8;
    localparam int HALF  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_valid;
    logic       ev_ready = 1'b1;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [3:0] ev_count;
    logic       frame_err;
    logic       overflow;

    ps2_key_event_ctrl #(.TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .ev_count  (ev_count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int max_cnt  = 0;
    logic [9:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: counts pulses and compares every accepted event with the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overflow) ov_cnt++;
            if (int'(ev_count) > max_cnt) max_cnt = int'(ev_count);
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {22'd0, ev_ext, ev_break, ev_code}, 32'h3FF);
                end else begin
                    check("event", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        send_bit(1'b1);
        wait_cyc(HALF);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (ev_count != 4'd0 && k < 200) begin
            wait_cyc(1);
            k++;
        end
        check(name, {28'd0, ev_count}, 32'd0);
    endtask

    int fe0, ov0;
    logic [7:0] b1c;

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, ev_valid}, 32'd0);
        check("rst_count", {28'd0, ev_count}, 32'd0);
        check("rst_code", {24'd0, ev_code}, 32'd0);
        check("rst_err", {30'd0, frame_err, overflow}, 32'd0);
        wait_cyc(10);

        // 1: 0x1C with latency check around the stop-bit fall
        b1c = 8'h1C;
        exp_q.push_back({2'b00, 8'h1C});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b1c[i]);
        send_bit(1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        check("t1_valid_e1", {31'd0, ev_valid}, 32'd0);
        @(negedge clk);
        check("t1_valid_e2", {31'd0, ev_valid}, 32'd1);
        check("t1_count_e2", {28'd0, ev_count}, 32'd1);
        @(negedge clk);
        check("t1_popped", {31'd0, ev_valid}, 32'd0);
        wait_cyc(HALF - 6);
        ps2_clk = 1'b1;
        wait_cyc(HALF);

        // 2: E0 F0 75 merged into one event
        max_cnt = 0;
        exp_q.push_back({2'b11, 8'h75});
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("t2_max_count", max_cnt, 32'd1);

        // 3: bad parity then good frame
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1);
        check("t3_parity_err", fe_cnt - fe0, 32'd1);
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0);
        check("t3_no_more_err", fe_cnt - fe0, 32'd1);

        // 4: partial frame aborted by timeout
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        ps2_data = 1'b1;
        wait_cyc(TMO + 10);
        check("t4_timeout_err", fe_cnt - fe0, 32'd1);
        exp_q.push_back({2'b00, 8'h23});
        send_frame(8'h23, 1'b0);
        check("t4_after_err", fe_cnt - fe0, 32'd1);

        // 5: fill past capacity with ev_ready low
        ev_ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back({2'b00, 8'(i)});
            send_frame(8'(i), 1'b0);
        end
        check("t5_count_full", {28'd0, ev_count}, 32'd8);
        check("t5_no_ovf_yet", ov_cnt - ov0, 32'd0);
        send_frame(8'h09, 1'b0);
        check("t5_count_still", {28'd0, ev_count}, 32'd8);
        check("t5_ovf", ov_cnt - ov0, 32'd1);
        check("t5_head", {24'd0, ev_code}, 32'h01);
        ev_ready = 1'b1;
        drain("t5_drained");

        // 6: reset mid-frame with a queued event
        ev_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        check("t6_pre_count", {28'd0, ev_count}, 32'd1);
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", {31'd0, ev_valid}, 32'd0);
        check("t6_rst_count", {28'd0, ev_count}, 32'd0);
        check("t6_rst_head", {22'd0, ev_ext, ev_break, ev_code}, 32'd0);
        check("t6_rst_pulses", {30'd0, frame_err, overflow}, 32'd0);
        ev_ready = 1'b1;
        wait_cyc(TMO + 10);
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(8'h5A, 1'b0);
        check("t6_no_err", fe_cnt - fe0, 32'd0);

        wait_cyc(20);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
